enc8to3_sync: RTL and testbench

- Registered 8-to-3 highest-priority encoder with enable and a valid flag.
- Converts an 8-bit request/flag vector into the 3-bit index of its highest set bit.
- Sits between request-generating logic and index-consuming logic such as mux selects and arbiters.
- Output is registered on the clock, giving consumers a glitch-free, timing-clean index.

---
 rtl/enc_pkg.sv | 12 +
 rtl/prio_enc8_comb.sv | 31 +++
 rtl/enc8to3_sync.sv | 53 +++++
 tb/tb_enc8to3_sync.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// enc_pkg: constants and types shared by the 8-to-3 priority encoder files.
//   ENC_IN_W  : width of the request vector
//   ENC_IDX_W : width of the encoded index
//   enc_idx_t : encoded index type
package enc_pkg;

  localparam int ENC_IN_W  = 8;
  localparam int ENC_IDX_W = 3;

  typedef logic [ENC_IDX_W-1:0] enc_idx_t;

endpackage : enc_pkg

// File: rtl/prio_enc8_comb.sv
// prio_enc8_comb: combinational highest-index-wins priority encoder.
// Ports:
//   a          in  [7:0] request vector, bit i = request i active
//   en         in        enable; 0 forces a zero index and invalid result
//   idx_next   out [2:0] index of the highest set bit of a (0 when invalid)
//   valid_next out       1 when en=1 and a has at least one bit set
module prio_enc8_comb
  import enc_pkg::*;
(
  input  logic [ENC_IN_W-1:0] a,
  input  logic                en,
  output enc_idx_t            idx_next,
  output logic                valid_next
);

  always_comb begin
    idx_next   = '0;
    valid_next = 1'b0;
    if (en) begin
      // Ascending scan: a later (higher) set bit overwrites a lower one,
      // so the highest index wins.
      for (int i = 0; i < ENC_IN_W; i++) begin
        if (a[i]) begin
          idx_next   = enc_idx_t'(i);
          valid_next = 1'b1;
        end
      end
    end
  end

endmodule : prio_enc8_comb

// File: rtl/enc8to3_sync.sv
// enc8to3_sync: registered 8-to-3 priority encoder with enable and valid.
// One clock of latency from a/en to y/valid; a fresh result every cycle.
// Ports:
//   clk   in        system clock, rising edge
//   rst_n in        asynchronous active-low reset (y=0, valid=0)
//   a     in  [7:0] request vector
//   en    in        encoder enable
//   y     out [2:0] registered index of the highest set bit of a
//   valid out       registered flag: en=1 and a != 0
module enc8to3_sync
  import enc_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ENC_IN_W-1:0] a,
  input  logic                en,
  output enc_idx_t            y,
  output logic                valid
);

  enc_idx_t idx_next;
  logic     valid_next;
  enc_idx_t y_d;
  enc_idx_t y_q;
  logic     valid_d;
  logic     valid_q;

  prio_enc8_comb u_prio_enc8_comb (
    .a          (a),
    .en         (en),
    .idx_next   (idx_next),
    .valid_next (valid_next)
  );

  always_comb begin
    y_d     = idx_next;
    valid_d = valid_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      y_q     <= y_d;
      valid_q <= valid_d;
    end
  end

  assign y     = y_q;
  assign valid = valid_q;

endmodule : enc8to3_sync

// File: tb/tb_enc8to3_sync.sv
// tb_enc8to3_sync: self-checking bench for enc8to3_sync.
// Inputs are driven on the falling edge; outputs are sampled 1 time unit
// after the rising edge that registers them.
module tb_enc8to3_sync;

  logic       clk;
  logic       rst_n;
  logic [7:0] a;
  logic       en;
  logic [2:0] y;
  logic       valid;

  int total = 0;
  int bad   = 0;

  enc8to3_sync dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .en    (en),
    .y     (y),
    .valid (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: index of highest set bit = floor(log2(a)) = clog2(a+1)-1.
  function automatic logic [2:0] ref_y(input logic [7:0] av, input logic ev);
    int v;
    if (!ev || av == 8'd0) return 3'd0;
    v = int'(av);
    return 3'($clog2(v + 1) - 1);
  endfunction

  function automatic logic ref_v(input logic [7:0] av, input logic ev);
    return ev && (av != 8'd0);
  endfunction

  // Drive one input pair on the falling edge, then wait until just after
  // the rising edge that registers it.
  task automatic apply(input logic [7:0] av, input logic ev);
    @(negedge clk);
    a  = av;
    en = ev;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a     = 8'hFF;
    en    = 1'b1;
    #2;
    total++;
    if (y !== 3'd0 || valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_initial: y=%0d valid=%0b, expected y=0 valid=0", y, valid);
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      total++;
      if (y !== 3'd0 || valid !== 1'b0) begin
        bad++;
        $display("FAIL reset_hold%0d: y=%0d valid=%0b, expected y=0 valid=0", k, y, valid);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (y !== 3'd7 || valid !== 1'b1) begin
      bad++;
      $display("FAIL reset_release: y=%0d valid=%0b, expected y=7 valid=1", y, valid);
    end
    $display("reset: y=%0d valid=%0b after release", y, valid);
  endtask

  task automatic test_single_hot();
    logic [7:0] av;
    for (int i = 0; i < 8; i++) begin
      av = 8'd1 << i;
      apply(av, 1'b1);
      total++;
      if (y !== 3'(i) || valid !== 1'b1) begin
        bad++;
        $display("FAIL single_hot a=%b: y=%0d valid=%0b, expected y=%0d valid=1", av, y, valid, i);
      end
      $display("single_hot a=%b -> y=%0d valid=%0b", av, y, valid);
    end
  endtask

  task automatic test_multi_hot();
    logic [7:0] vecs [4];
    logic [2:0] exp_y [4];
    vecs  = '{8'b00000011, 8'b00000111, 8'b00000110, 8'b00000101};
    exp_y = '{3'd1, 3'd2, 3'd2, 3'd2};
    for (int i = 0; i < 4; i++) begin
      apply(vecs[i], 1'b1);
      total++;
      if (y !== exp_y[i] || valid !== 1'b1) begin
        bad++;
        $display("FAIL multi_hot a=%b: y=%0d valid=%0b, expected y=%0d valid=1", vecs[i], y, valid, exp_y[i]);
      end
      $display("multi_hot a=%b -> y=%0d valid=%0b", vecs[i], y, valid);
    end
  endtask

  task automatic test_zero();
    apply(8'h00, 1'b1);
    total++;
    if (y !== 3'd0 || valid !== 1'b0) begin
      bad++;
      $display("FAIL zero_input: y=%0d valid=%0b, expected y=0 valid=0", y, valid);
    end
    $display("zero a=00000000 -> y=%0d valid=%0b", y, valid);
    apply(8'h01, 1'b1);
    total++;
    if (y !== 3'd0 || valid !== 1'b1) begin
      bad++;
      $display("FAIL zero_bit0: y=%0d valid=%0b, expected y=0 valid=1", y, valid);
    end
    $display("zero a=00000001 -> y=%0d valid=%0b", y, valid);
  endtask

  task automatic test_enable();
    logic [7:0] vecs [3];
    vecs = '{8'b00000010, 8'b00000101, 8'b11111111};
    for (int i = 0; i < 3; i++) begin
      apply(vecs[i], 1'b0);
      total++;
      if (y !== 3'd0 || valid !== 1'b0) begin
        bad++;
        $display("FAIL enable_off a=%b: y=%0d valid=%0b, expected y=0 valid=0", vecs[i], y, valid);
      end
      $display("enable_off a=%b -> y=%0d valid=%0b", vecs[i], y, valid);
    end
    apply(8'b00000100, 1'b1);
    total++;
    if (y !== 3'd2 || valid !== 1'b1) begin
      bad++;
      $display("FAIL enable_back: y=%0d valid=%0b, expected y=2 valid=1", y, valid);
    end
    $display("enable_on a=00000100 -> y=%0d valid=%0b", y, valid);
  endtask

  // Back-to-back random vectors, one per cycle, against the model.
  task automatic test_back_to_back();
    logic [7:0] av;
    logic       ev;
    logic [2:0] ey;
    logic       evld;
    for (int i = 0; i < 200; i++) begin
      av   = 8'($urandom);
      ev   = ($urandom_range(0, 3) != 0);
      ey   = ref_y(av, ev);
      evld = ref_v(av, ev);
      apply(av, ev);
      total++;
      if (y !== ey || valid !== evld) begin
        bad++;
        $display("FAIL random a=%b en=%0b: y=%0d valid=%0b, expected y=%0d valid=%0b", av, ev, y, valid, ey, evld);
      end
      $display("random a=%b en=%0b -> y=%0d valid=%0b", av, ev, y, valid);
    end
  endtask

  task automatic test_async_reset();
    apply(8'h80, 1'b1);
    total++;
    if (y !== 3'd7 || valid !== 1'b1) begin
      bad++;
      $display("FAIL async_pre: y=%0d valid=%0b, expected y=7 valid=1", y, valid);
    end
    // Mid-cycle assertion, well away from any clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (y !== 3'd0 || valid !== 1'b0) begin
      bad++;
      $display("FAIL async_assert: y=%0d valid=%0b, expected y=0 valid=0", y, valid);
    end
    $display("async_reset asserted -> y=%0d valid=%0b", y, valid);
    @(posedge clk);
    #1;
    total++;
    if (y !== 3'd0 || valid !== 1'b0) begin
      bad++;
      $display("FAIL async_hold: y=%0d valid=%0b, expected y=0 valid=0", y, valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (y !== 3'd7 || valid !== 1'b1) begin
      bad++;
      $display("FAIL async_release: y=%0d valid=%0b, expected y=7 valid=1", y, valid);
    end
    $display("async_reset released -> y=%0d valid=%0b", y, valid);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    a     = 8'h00;
    en    = 1'b0;
    test_reset();
    test_single_hot();
    test_multi_hot();
    test_zero();
    test_enable();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_enc8to3_sync
